// File: rtl/ifu_prefetch_if.sv
// Signal bundle joining the instruction prefetcher to its redirect source,
// its instruction consumer and its memory port.
interface ifu_prefetch_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  ioRedirect_valid;
  logic [63:0]           ioRedirect_npc;
  logic                  ioRedirect_ready;

  logic                  ioIFU_valid;
  logic                  ioIFU_ready;
  logic [31:0]           ioIFU_inst;
  logic [63:0]           ioIFU_pc;
  logic [63:0]           ioIFU_pc4;

  logic                  ioMem_ren;
  logic [ADDR_WIDTH-1:0] ioMem_addr;
  logic [63:0]           ioMem_rData;
  logic                  ioMem_rvalid;
  logic                  ioMem_wen;
  logic [7:0]            ioMem_wMask;
  logic [63:0]           ioMem_wData;

  // Prefetcher side
  modport master (
    input  ioRedirect_valid,
    input  ioRedirect_npc,
    output ioRedirect_ready,
    output ioIFU_valid,
    input  ioIFU_ready,
    output ioIFU_inst,
    output ioIFU_pc,
    output ioIFU_pc4,
    output ioMem_ren,
    output ioMem_addr,
    input  ioMem_rData,
    input  ioMem_rvalid,
    output ioMem_wen,
    output ioMem_wMask,
    output ioMem_wData
  );

  // Environment side: redirect source, consumer and memory
  modport slave (
    output ioRedirect_valid,
    output ioRedirect_npc,
    input  ioRedirect_ready,
    input  ioIFU_valid,
    output ioIFU_ready,
    input  ioIFU_inst,
    input  ioIFU_pc,
    input  ioIFU_pc4,
    input  ioMem_ren,
    input  ioMem_addr,
    output ioMem_rData,
    output ioMem_rvalid,
    input  ioMem_wen,
    input  ioMem_wMask,
    input  ioMem_wData
  );
endinterface

// File: rtl/ifu_prefetch.sv
// Instruction prefetcher: issues one sequential read at a time, queues the
// selected 32-bit word with its pc, and flushes on redirect.
module ifu_prefetch #(
  parameter logic [63:0] RESET_PC    = 64'h8000_0000,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned START_DELAY = 10,
  parameter int unsigned ADDR_WIDTH  = 32
) (
  input  logic           clock,
  input  logic           reset,
  ifu_prefetch_if.master bus
);

  localparam int unsigned PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W     = PTR_W + 1;
  localparam int unsigned BOOT_W    = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
  localparam int unsigned BOOT_LAST = (START_DELAY > 0) ? START_DELAY - 1 : 0;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } q_entry_t;

  state_e            state_q;
  state_e            state_d;
  logic [BOOT_W-1:0] boot_cnt;
  logic [63:0]       fetch_pc;
  logic [63:0]       req_pc;

  q_entry_t          queue_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;

  logic              redirect_c;
  logic              boot_done_c;
  logic              q_full_c;
  logic              mem_ren_c;
  logic              push_c;
  logic              pop_c;
  logic              ifu_valid_c;
  q_entry_t          push_entry_c;
  q_entry_t          head_c;

  assign redirect_c  = bus.ioRedirect_valid;
  assign boot_done_c = (START_DELAY == 0) || (boot_cnt == BOOT_W'(BOOT_LAST));
  assign q_full_c    = (count == CNT_W'(FIFO_DEPTH));
  assign ifu_valid_c = (count != '0) && !redirect_c;
  assign pop_c       = ifu_valid_c && bus.ioIFU_ready;

  // The word inside the returned doubleword is chosen by pc bit 2
  assign push_entry_c.pc   = req_pc;
  assign push_entry_c.inst = req_pc[2] ? bus.ioMem_rData[63:32] : bus.ioMem_rData[31:0];

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_BOOT: begin
        if (redirect_c || boot_done_c) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (!redirect_c && !q_full_c) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.ioMem_rvalid) begin
          state_d = S_FETCH;
        end else if (redirect_c) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (bus.ioMem_rvalid) begin
          state_d = S_FETCH;
        end
      end
      default: state_d = S_BOOT;
    endcase
  end

  // Output logic: issue strobe and queue push
  always_comb begin
    mem_ren_c = 1'b0;
    push_c    = 1'b0;
    case (state_q)
      S_FETCH: mem_ren_c = !q_full_c && !redirect_c;
      S_WAIT:  push_c    = bus.ioMem_rvalid && !redirect_c;
      default: ;
    endcase
  end

  // Boot counter, fetch pc, outstanding request pc, queue pointers and count
  always_ff @(posedge clock) begin
    if (reset) begin
      boot_cnt <= '0;
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if ((state_q == S_BOOT) && !boot_done_c) begin
        boot_cnt <= boot_cnt + BOOT_W'(1);
      end
      if (redirect_c) begin
        fetch_pc <= bus.ioRedirect_npc & ~64'd3;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
      end else begin
        if (mem_ren_c) begin
          fetch_pc <= fetch_pc + 64'd4;
          req_pc   <= fetch_pc;
        end
        if (push_c) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (pop_c) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        case ({push_c, pop_c})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: ;
        endcase
      end
    end
  end

  // Queue storage; contents are only meaningful below the count
  always_ff @(posedge clock) begin
    if (push_c) begin
      queue_q[wr_ptr] <= push_entry_c;
    end
  end

  assign head_c = queue_q[rd_ptr];

  assign bus.ioRedirect_ready = 1'b1;
  assign bus.ioIFU_valid      = ifu_valid_c;
  assign bus.ioIFU_inst       = head_c.inst;
  assign bus.ioIFU_pc         = head_c.pc;
  assign bus.ioIFU_pc4        = head_c.pc + 64'd4;
  assign bus.ioMem_ren        = mem_ren_c;
  assign bus.ioMem_addr       = {fetch_pc[ADDR_WIDTH-1:3], 3'b000};
  assign bus.ioMem_wen        = 1'b0;
  assign bus.ioMem_wMask      = 8'd0;
  assign bus.ioMem_wData      = 64'd0;

endmodule

// File: tb/tb_ifu_prefetch.sv
// Bench for ifu_prefetch: directed scenarios then random traffic, all checked
// against an in-order instruction-stream model with a latency-driven memory.
module tb_ifu_prefetch;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned DELAY  = 10;
  localparam logic [63:0] RST_PC = 64'h8000_0000;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  ifu_prefetch_if #(.ADDR_WIDTH(32)) bus ();

  ifu_prefetch #(
    .RESET_PC   (RST_PC),
    .FIFO_DEPTH (DEPTH),
    .START_DELAY(DELAY),
    .ADDR_WIDTH (32)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t        exp_q[$];
  int          total;
  int          passed;

  logic        rst;
  logic        redir_v;
  logic [63:0] redir_npc;
  logic        ready;
  int          lat;
  logic        redir_at_rv2;
  logic [63:0] redir_at_rv2_npc;

  logic [63:0] m_fetch_pc;
  logic [63:0] m_req_pc;
  logic        m_pending;
  logic        m_live;
  logic        m_redirected;
  logic        rst_seen;
  int          since_rst;

  logic        mem_busy;
  int          mem_wait;
  logic [31:0] mem_addr;
  logic [31:0] salt;

  int          first_ren;
  int          first_valid;
  int          ren_total;
  logic        last_ren;
  logic [31:0] last_ren_addr;
  logic [31:0] first_ren_addr;

  function automatic logic [63:0] mem_data(input logic [31:0] a);
    logic [31:0] h;
    h = (a ^ salt) * 32'h9E37_79B1;
    return {h ^ 32'h1111_1111, ~h + a};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance.
  task automatic cycle();
    logic        rv;
    logic        ren_exp;
    logic        val_exp;
    logic [63:0] data;
    exp_t        e;
    rv = mem_busy && (mem_wait == 1);
    if (redir_at_rv2 && rv && !rst && exp_q.size() == 2) begin
      redir_v      = 1'b1;
      redir_npc    = redir_at_rv2_npc;
      ready        = 1'b1;
      redir_at_rv2 = 1'b0;
    end
    if (rst) redir_v = 1'b0;
    reset                = rst;
    bus.ioRedirect_valid = redir_v;
    bus.ioRedirect_npc   = redir_npc;
    bus.ioIFU_ready      = ready;
    bus.ioMem_rvalid     = rv;
    bus.ioMem_rData      = rv ? mem_data(mem_addr) : {$urandom, $urandom};
    #1;
    last_ren = bus.ioMem_ren;
    if (bus.ioMem_ren === 1'b1) begin
      ren_total++;
      last_ren_addr = bus.ioMem_addr;
    end
    chk("const_ctl", 64'({bus.ioRedirect_ready, bus.ioMem_wen, bus.ioMem_wMask}), 64'h200);
    chk("const_wdata", bus.ioMem_wData, 64'd0);
    if (rst) begin
      if (rst_seen) begin
        chk("rst_ren", 64'(bus.ioMem_ren), 64'd0);
        chk("rst_valid", 64'(bus.ioIFU_valid), 64'd0);
      end
      exp_q.delete();
      m_fetch_pc   = RST_PC;
      m_pending    = 1'b0;
      m_live       = 1'b0;
      m_redirected = 1'b0;
      since_rst    = 0;
      first_ren    = -1;
      first_valid  = -1;
      rst_seen     = 1'b1;
    end else begin
      rst_seen = 1'b0;
      if (bus.ioMem_ren === 1'b1 && first_ren < 0) begin
        first_ren      = since_rst;
        first_ren_addr = bus.ioMem_addr;
      end
      if (bus.ioIFU_valid === 1'b1 && first_valid < 0) first_valid = since_rst;
      ren_exp = (since_rst >= int'(DELAY) || m_redirected) && !m_pending &&
                (exp_q.size() < int'(DEPTH)) && !redir_v;
      chk("ren", 64'(bus.ioMem_ren), 64'(ren_exp));
      if (ren_exp) chk("addr", 64'(bus.ioMem_addr), 64'({m_fetch_pc[31:3], 3'b000}));
      val_exp = (exp_q.size() != 0) && !redir_v;
      chk("valid", 64'(bus.ioIFU_valid), 64'(val_exp));
      if (val_exp) begin
        chk("pc", bus.ioIFU_pc, exp_q[0].pc);
        chk("inst", 64'(bus.ioIFU_inst), 64'(exp_q[0].inst));
        chk("pc4", bus.ioIFU_pc4, exp_q[0].pc + 64'd4);
        if (ready) void'(exp_q.pop_front());
      end
      if (rv && m_pending) begin
        if (m_live && !redir_v) begin
          data   = mem_data({m_req_pc[31:3], 3'b000});
          e.pc   = m_req_pc;
          e.inst = m_req_pc[2] ? data[63:32] : data[31:0];
          exp_q.push_back(e);
        end
        m_pending = 1'b0;
        m_live    = 1'b0;
      end
      if (ren_exp) begin
        m_pending  = 1'b1;
        m_live     = 1'b1;
        m_req_pc   = m_fetch_pc;
        m_fetch_pc = m_fetch_pc + 64'd4;
      end
      if (redir_v) begin
        exp_q.delete();
        m_live       = 1'b0;
        m_fetch_pc   = redir_npc & ~64'd3;
        m_redirected = 1'b1;
      end
      since_rst++;
    end
    // Memory: one response exactly lat cycles after each strobe
    if (rv) mem_busy = 1'b0;
    else if (mem_busy) mem_wait--;
    if (bus.ioMem_ren === 1'b1) begin
      mem_busy = 1'b1;
      mem_wait = lat;
      mem_addr = bus.ioMem_addr;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic run_until_ren(input int budget);
    int n;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!last_ren && n < budget);
    chk("ren_timeout", 64'(last_ren), 64'd1);
  endtask

  initial begin
    int sel;
    total = 0; passed = 0;
    salt = $urandom;
    rst = 1'b1; redir_v = 1'b0; redir_npc = '0; ready = 1'b0; lat = 1;
    redir_at_rv2 = 1'b0; redir_at_rv2_npc = '0;
    m_fetch_pc = RST_PC; m_req_pc = '0; m_pending = 1'b0; m_live = 1'b0;
    m_redirected = 1'b0; rst_seen = 1'b0; since_rst = 0;
    mem_busy = 1'b0; mem_wait = 0; mem_addr = '0;
    first_ren = -1; first_valid = -1; ren_total = 0; last_ren = 1'b0;
    last_ren_addr = '0; first_ren_addr = '0;
    reset = 1'b1;
    bus.ioRedirect_valid = 1'b0; bus.ioRedirect_npc = '0; bus.ioIFU_ready = 1'b0;
    bus.ioMem_rvalid = 1'b0; bus.ioMem_rData = '0;
    @(posedge clock);
    #1;

    // Reset, then boot with a stalled consumer and latency 1
    repeat (3) cycle();
    rst = 1'b0;
    ren_total = 0;
    repeat (40) cycle();
    chk("boot_first_ren", 64'(first_ren), 64'd10);
    chk("boot_first_addr", 64'(first_ren_addr), 64'h8000_0000);
    chk("boot_first_valid", 64'(first_valid), 64'd12);
    chk("stall_ren_count", 64'(ren_total), 64'd4);
    chk("stall_ren_idle", 64'(last_ren), 64'd0);

    // Drain the queue, fetch resumes
    ready = 1'b1;
    repeat (30) cycle();
    chk("resume_fetch", 64'(ren_total > 4), 64'd1);

    // Redirect while waiting; the late response must be dropped
    lat = 3;
    run_until_ren(40);
    redir_v = 1'b1; redir_npc = 64'h8000_1000;
    cycle();
    redir_v = 1'b0;
    run_until_ren(40);
    chk("redir_wait_addr", 64'(last_ren_addr), 64'h8000_1000);
    repeat (10) cycle();

    // Redirect on the same cycle as a response with two entries queued
    ready = 1'b0; lat = 2;
    redir_v = 1'b1; redir_npc = 64'h8000_0100;
    cycle();
    redir_v = 1'b0;
    redir_at_rv2 = 1'b1; redir_at_rv2_npc = 64'h8000_2000;
    for (int i = 0; i < 60 && redir_at_rv2; i++) cycle();
    chk("redir_rv_hit", 64'(redir_at_rv2), 64'd0);
    redir_v = 1'b0; ready = 1'b0;
    run_until_ren(40);
    chk("redir_rv_addr", 64'(last_ren_addr), 64'h8000_2000);
    ready = 1'b1;
    repeat (10) cycle();

    // pc4 wraps at the top of the address space; npc low bits are masked
    redir_v = 1'b1; redir_npc = 64'hFFFF_FFFF_FFFF_FFFF;
    cycle();
    redir_v = 1'b0;
    repeat (20) cycle();

    // Reset pulsed mid-request, stale response arrives during boot
    lat = 4;
    run_until_ren(40);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    repeat (30) cycle();
    chk("rst_first_ren", 64'(first_ren), 64'd10);
    chk("rst_first_addr", 64'(first_ren_addr), 64'h8000_0000);
    chk("rst_first_valid", 64'(first_valid), 64'd15);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      ready = ($urandom_range(0, 3) != 0);
      lat   = $urandom_range(1, 4);
      if (rst) rst = ($urandom_range(0, 1) == 0);
      else     rst = ($urandom_range(0, 399) == 0);
      redir_v = !rst && (since_rst >= 6) && ($urandom_range(0, 29) == 0);
      sel = $urandom_range(0, 3);
      case (sel)
        0:       redir_npc = {32'h0, 32'h8000_0000 | 32'($urandom_range(0, 16'hFFFF))};
        1:       redir_npc = {$urandom, $urandom};
        2:       redir_npc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
        default: redir_npc = 64'({$urandom_range(0, 255), 12'h000});
      endcase
      cycle();
    end
    rst = 1'b0; redir_v = 1'b0;
    repeat (5) cycle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ifu_prefetch.md
IFU_PREFETCH -- requirements
Module: ifu_prefetch

Interface
REQ-001 Parameter RESET_PC, default 64'h80000000, first fetch address after reset.
REQ-002 Parameter FIFO_DEPTH, default 4, instruction queue entries; power of two, 2..16.
REQ-003 Parameter START_DELAY, default 10, cycles from reset release to the first fetch.
REQ-004 Parameter ADDR_WIDTH, default 32, memory address width.
REQ-005 Port clock, input, 1, single clock for all state.
REQ-006 Port reset, input, 1, synchronous, active-high.
REQ-007 Port ioRedirect_valid, input, 1, redirect request from WBU.
REQ-008 Port ioRedirect_npc, input, 64, redirect target PC.
REQ-009 Port ioRedirect_ready, output, 1, constant 1.
REQ-010 Port ioIFU_valid, output, 1, queue head valid.
REQ-011 Port ioIFU_ready, input, 1, consumer accepts the head.
REQ-012 Port ioIFU_inst, output, 32, head instruction.
REQ-013 Port ioIFU_pc, output, 64, head PC.
REQ-014 Port ioIFU_pc4, output, 64, head PC + 4.
REQ-015 Port ioMem_ren, output, 1, one-cycle read request strobe.
REQ-016 Port ioMem_addr, output, ADDR_WIDTH, doubleword-aligned read address.
REQ-017 Port ioMem_rData, input, 64, read data.
REQ-018 Port ioMem_rvalid, input, 1, read data valid; earliest one cycle after ren; exactly one per request.
REQ-019 Ports ioMem_wen (1), ioMem_wMask (8), ioMem_wData (64), outputs, constant 0.

Function
REQ-020 The FSM SHALL have states BOOT, FETCH, WAIT and DRAIN.
REQ-021 BOOT: a counter SHALL count START_DELAY cycles after reset release, then move to FETCH.
REQ-022 FETCH with queue count < FIFO_DEPTH: ioMem_ren=1 combinationally, ioMem_addr={fetch_pc[ADDR_WIDTH-1:3],3'b000}, fetch_pc<=fetch_pc+4, next state WAIT.
REQ-023 FETCH with a full queue: ren=0, remain in FETCH.
REQ-024 At most one memory request SHALL be outstanding.
REQ-025 WAIT with rvalid: push {inst, pc}; next state FETCH.
REQ-026 The pushed inst SHALL be rData[63:32] if the request pc[2]=1, else rData[31:0].
REQ-027 A pushed entry SHALL be visible on ioIFU_* the cycle after rvalid.
REQ-028 Sustained fetch throughput SHALL be one instruction per (memory latency + 1) cycles.
REQ-029 The queue SHALL be a circular buffer with wrap-around pointers.
REQ-030 ioIFU_valid = (count != 0) && !ioRedirect_valid.
REQ-031 A pop SHALL occur on ioIFU_valid && ioIFU_ready.
REQ-032 Simultaneous push and pop SHALL leave count unchanged.
REQ-033 A push SHALL never target a full queue, because space is checked at issue time.
REQ-034 ioIFU_pc4 SHALL equal head pc + 4, truncated to 64 bits (0xFFFFFFFFFFFFFFFC+4 = 0).
REQ-035 Redirect (ioRedirect_valid=1) in any state: queue flushed (count, pointers <= 0); fetch_pc <= {npc[63:2],2'b00}.
REQ-036 Redirect in BOOT or FETCH: next state FETCH; an issue in that same cycle SHALL be suppressed.
REQ-037 Redirect in WAIT with rvalid=1: response discarded, next state FETCH.
REQ-038 Redirect in WAIT with rvalid=0: next state DRAIN.
REQ-039 DRAIN: ren=0; the next rvalid SHALL be discarded, then FETCH; a further redirect in DRAIN updates fetch_pc and stays in DRAIN.
REQ-040 Redirect has priority over push and pop in the same cycle.

Reset
REQ-041 Reset SHALL give state=BOOT, boot counter=0, fetch_pc=RESET_PC, queue empty.
REQ-042 Reset SHALL give ioIFU_valid=0, ioMem_ren=0, ioMem_wen/wMask/wData=0.
REQ-043 Reset asserted mid-request SHALL abandon the request; a stale rvalid received in BOOT SHALL be ignored.
REQ-044 Output ioIFU_inst/pc/pc4 values SHALL be don't-care while ioIFU_valid=0.

Verification
REQ-045 Boot: release reset, memory latency 1 -> ren first at cycle 10 with addr 0x80000000; ioIFU_valid at cycle 12 with pc=0x80000000, inst=rData[31:0].
REQ-046 Streaming with ioIFU_ready=0, DEPTH=4 -> exactly 4 requests issued (pc 0x80000000..0x8000000C), then ren stays 0; ioIFU_ready=1 -> entries pop in order and fetch resumes.
REQ-047 Odd-word select: pc 0x80000004, rData=0x11111111_22222222 -> inst=0x11111111.
REQ-048 Redirect in WAIT to 0x80001000, rvalid two cycles later -> that response dropped; next ren addr 0x80001000; queue empty in between.
REQ-049 Redirect coincident with rvalid and pop, count=2 -> count=0, no push, next request at the new npc.
REQ-050 Reset pulsed in WAIT, stale rvalid 3 cycles later -> no push; boot sequence restarts from 0x80000000.
